// File: rtl/aes_input_loader.sv
// aes_input_loader: assembles a big-endian byte stream into the 128-bit key and
// plaintext buses of the aes core. It fires a one-cycle start and then holds both
// buses until the core reports done, or until the optional wait limit expires.
module aes_input_loader #(
  parameter int WAIT_LIMIT = 0,   // max cycles in WAIT_DONE; 0 disables the timeout
  parameter int CNT_W      = 16   // wait counter width, must hold WAIT_LIMIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         key_reuse,
  input  logic         aes_done,
  output logic [127:0] key,
  output logic [127:0] word,
  output logic         start,
  output logic         busy,
  output logic         key_valid,
  output logic         timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_LOAD_WORD,
    S_ISSUE,
    S_WAIT_DONE
  } state_t;

  localparam bit             TIMEOUT_EN = (WAIT_LIMIT != 0);
  localparam logic [CNT_W-1:0] LAST_WAIT = TIMEOUT_EN ? CNT_W'(WAIT_LIMIT - 1) : '0;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       byte_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic             fire;
  logic             last_byte;
  logic             expire;

  // Ready depends only on state, so the handshake never loops back through next-state logic.
  assign in_ready  = (state == S_LOAD_KEY) || (state == S_LOAD_WORD);
  assign fire      = in_valid && in_ready;
  assign last_byte = fire && (byte_cnt == 4'd15);

  // Next-state and strobe decode.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    state_nxt = state;
    start     = 1'b0;
    busy      = 1'b0;
    expire    = 1'b0;
    case (state)
      S_IDLE:      state_nxt = (key_reuse && key_valid) ? S_LOAD_WORD : S_LOAD_KEY;
      S_LOAD_KEY:  if (last_byte) state_nxt = S_LOAD_WORD;
      S_LOAD_WORD: if (last_byte) state_nxt = S_ISSUE;
      S_ISSUE: begin
        start     = 1'b1;
        busy      = 1'b1;
        state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        busy = 1'b1;
        // A done in the expiry cycle wins: the block completed, so no timeout.
        if (aes_done) begin
          state_nxt = S_IDLE;
        end else if (TIMEOUT_EN && (wait_cnt == LAST_WAIT)) begin
          state_nxt = S_IDLE;
          expire    = 1'b1;
        end
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values, independent of block ordering.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Byte counter and shift-in of the key/word buses; buses are frozen outside loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      key      <= '0;
      word     <= '0;
    end else if (fire) begin
      byte_cnt <= byte_cnt + 4'd1;
      if (state == S_LOAD_KEY) key  <= {key[119:0], in_data};
      else                     word <= {word[119:0], in_data};
    end
  end

  // Wait-cycle counter: counts while staying in WAIT_DONE, clears on any exit.
  always_ff @(posedge clk) begin
    if (rst)                                                   wait_cnt <= '0;
    else if (state == S_WAIT_DONE && state_nxt == S_WAIT_DONE) wait_cnt <= wait_cnt + CNT_W'(1);
    else                                                       wait_cnt <= '0;
  end

  // Key-held flag: cleared when a new key load begins or on expiry, set on the 16th key byte.
  always_ff @(posedge clk) begin
    if (rst)                                          key_valid <= 1'b0;
    else if (state == S_IDLE && state_nxt == S_LOAD_KEY) key_valid <= 1'b0;
    else if (state == S_LOAD_KEY && last_byte)        key_valid <= 1'b1;
    else if (expire)                                  key_valid <= 1'b0;
  end

  // Timeout pulse, registered so it appears in the IDLE cycle after expiry.
  always_ff @(posedge clk) begin
    if (rst) timeout <= 1'b0;
    else     timeout <= expire;
  end

endmodule

// File: tb/tb_aes_input_loader.sv
// Self-checking bench for aes_input_loader: directed blocks from the test plan
// followed by randomized blocks, checked against a transaction-level model.
module tb_aes_input_loader;

  localparam int WAIT_LIMIT = 8;

  logic         clk;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         key_reuse;
  logic         aes_done;
  logic [127:0] key;
  logic [127:0] word;
  logic         start;
  logic         busy;
  logic         key_valid;
  logic         timeout;

  aes_input_loader #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key_reuse (key_reuse),
    .aes_done  (aes_done),
    .key       (key),
    .word      (word),
    .start     (start),
    .busy      (busy),
    .key_valid (key_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what the core should currently see.
  logic [127:0] m_key;
  logic [127:0] m_word;
  bit           m_kv;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Assert reset for one edge, verify reset values; returns at the IDLE negedge.
  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    aes_done = 1'b0;
    @(negedge clk);
    check("rst_key",      key,       '0);
    check("rst_word",     word,      '0);
    check("rst_in_ready", in_ready,  0);
    check("rst_start",    start,     0);
    check("rst_busy",     busy,      0);
    check("rst_key_valid", key_valid, 0);
    check("rst_timeout",  timeout,   0);
    m_key  = '0;
    m_word = '0;
    m_kv   = 1'b0;
    rst    = 1'b0;
  endtask

  // One block, entered at the negedge of an IDLE cycle and left at the next one.
  // gap: 0 = valid held high, 1 = toggle, 2 = random. done_dly: WAIT_DONE cycle
  // index at which done is driven (outside 0..7 means never). abort_at: accepted
  // byte count at which reset is forced (-1 = none). stray: spurious done pulses.
  task automatic run_block(input logic [127:0] k, input logic [127:0] w, input bit reuse,
                           input int gap, input int done_dly, input int abort_at,
                           input bit stray);
    logic [7:0] q[$];
    bit         need_key;
    bit         v;
    bit         exp_to;
    bit         ended;
    int         n;
    int         idx;
    int         cyc;

    check("idle_in_ready", in_ready, 0);
    check("idle_busy",     busy,     0);
    key_reuse = reuse;
    in_valid  = 1'b0;
    aes_done  = 1'b0;
    need_key  = !(reuse && m_kv);
    q = {};
    if (need_key) for (int i = 0; i < 16; i++) q.push_back(k[127-8*i -: 8]);
    for (int i = 0; i < 16; i++) q.push_back(w[127-8*i -: 8]);
    n   = q.size();
    idx = 0;
    cyc = 0;
    @(negedge clk);

    while (idx < n) begin
      if (idx == abort_at) begin
        do_reset();
        return;
      end
      if (cyc >= 400) begin
        check("load_cycle_bound", 0, 1);
        do_reset();
        return;
      end
      check("load_in_ready", in_ready, 1);
      check("load_start",    start,    0);
      check("load_busy",     busy,     0);
      check("load_key_valid", key_valid, (need_key && idx < 16) ? 1'b0 : 1'b1);
      case (gap)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid  = v;
      in_data   = v ? q[idx] : 8'($urandom);
      aes_done  = stray && (($urandom_range(0, 3) == 0) || idx == n - 2);
      key_reuse = 1'($urandom_range(0, 1));
      @(posedge clk);
      if (v && in_ready) idx++;
      @(negedge clk);
      cyc++;
    end

    // ISSUE cycle: one cycle after the final accepted byte.
    m_word = w;
    if (need_key) begin
      m_key = k;
      m_kv  = 1'b1;
    end
    check("issue_start",     start,     1);
    check("issue_busy",      busy,      1);
    check("issue_in_ready",  in_ready,  0);
    check("issue_key",       key,       m_key);
    check("issue_word",      word,      m_word);
    check("issue_key_valid", key_valid, 1);
    in_valid = 1'($urandom_range(0, 1));
    in_data  = 8'($urandom);
    aes_done = stray;
    @(negedge clk);

    // WAIT_DONE cycles, c counts cycles since entry.
    ended  = 1'b0;
    exp_to = 1'b0;
    for (int c = 0; c < WAIT_LIMIT && !ended; c++) begin
      check("wait_start",    start,    0);
      check("wait_busy",     busy,     1);
      check("wait_in_ready", in_ready, 0);
      check("wait_timeout",  timeout,  0);
      check("wait_key",      key,      m_key);
      check("wait_word",     word,     m_word);
      aes_done  = (c == done_dly);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      key_reuse = 1'($urandom_range(0, 1));
      if (c == done_dly) begin
        ended = 1'b1;
      end else if (c == WAIT_LIMIT - 1) begin
        ended  = 1'b1;
        exp_to = 1'b1;
      end
      @(negedge clk);
    end

    // Back in IDLE.
    aes_done = 1'b0;
    in_valid = 1'b0;
    if (exp_to) m_kv = 1'b0;
    check("end_timeout",   timeout,   exp_to);
    check("end_busy",      busy,      0);
    check("end_start",     start,     0);
    check("end_key_valid", key_valid, m_kv);
    check("end_key",       key,       m_key);
    check("end_word",      word,      m_word);
  endtask

  initial begin
    logic [127:0] k1;
    logic [127:0] w1;
    logic [127:0] w2;
    logic [127:0] kr;
    logic [127:0] wr;
    int           dd;
    int           ab;

    k1 = 128'h000102030405060708090a0b0c0d0e0f;
    w1 = 128'h00112233445566778899aabbccddeeff;
    w2 = 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    key_reuse = 1'b0;
    aes_done  = 1'b0;
    do_reset();

    // Full load, done five cycles into the wait.
    run_block(k1, w1, 1'b0, 0, 5, -1, 1'b0);
    // Key reuse: only the word is streamed.
    run_block(128'h0, w2, 1'b1, 0, 3, -1, 1'b0);
    // Gapped stream.
    run_block(k1, w1, 1'b0, 1, 2, -1, 1'b0);
    // Timeout, then a reuse request that must still load a key.
    run_block(w2, k1, 1'b0, 0, -1, -1, 1'b0);
    run_block(k1, w2, 1'b1, 0, 1, -1, 1'b0);
    // Done coincident with expiry: done wins.
    run_block(k1, w1, 1'b0, 2, WAIT_LIMIT - 1, -1, 1'b0);
    // Reset after 7 key bytes, then a clean block.
    run_block(w1, w2, 1'b0, 0, 0, 7, 1'b0);
    run_block(k1, w1, 1'b0, 0, 4, -1, 1'b0);
    // Stray done in LOAD_WORD and ISSUE.
    run_block(128'h0, w2, 1'b1, 0, 6, -1, 1'b1);

    for (int b = 0; b < 30; b++) begin
      kr = {$urandom, $urandom, $urandom, $urandom};
      wr = {$urandom, $urandom, $urandom, $urandom};
      dd = $urandom_range(0, 10);
      if (dd >= WAIT_LIMIT) dd = -1;
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 20) : -1;
      run_block(kr, wr, 1'($urandom_range(0, 1)), $urandom_range(0, 2), dd, ab,
                1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
